lsb_message_extractor: RTL and testbench

- Downstream neighbour of bit_changer_seq. Receives stego frames of FRAME_SIZE samples of BPS bits each, in the same format bit_changer_seq produces.
- Recovers one hidden message bit per sample: the LSB of each sample.
- Packs the recovered bits LSB-first into WORD_W-bit message words and hands them out over a valid/ack handshake.
- Supports backpressure, a flush of partial words and overflow reporting. This closes the embed/extract loop for self-checking benches and readback.

---
 rtl/lsb_message_extractor.sv | 129 ++++++++++++
 tb/tb_lsb_message_extractor.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsb_message_extractor.sv
// Recovers one hidden bit (the LSB) per stego sample and packs the bits LSB-first
// into WORD_W-bit message words delivered over a valid/ack handshake.
module lsb_message_extractor #(
   parameter int FRAME_SIZE = 1,
   parameter int BPS        = 8,
   parameter int WORD_W     = 8
) (
   input  logic                       in_clk,
   input  logic                       in_rst,
   input  logic                       in_enable,
   input  logic [FRAME_SIZE*BPS-1:0]  in_frame,
   input  logic                       in_flush,
   input  logic                       in_word_ack,
   output logic                       out_busy,
   output logic [WORD_W-1:0]          out_word,
   output logic                       out_valid,
   output logic                       out_last,
   output logic                       out_overflow,
   output logic [15:0]                out_word_cnt
);

   localparam int ACC_W = WORD_W + FRAME_SIZE;
   localparam int CNT_W = $clog2(ACC_W + 1);
   localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_W);
   localparam logic [CNT_W-1:0] FS_CNT   = CNT_W'(FRAME_SIZE);

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   state_t              r_state, w_state_next;
   logic [ACC_W-1:0]    r_acc, w_acc_next, w_acc_shift, w_msg_ext;
   logic [CNT_W-1:0]    r_cnt, w_cnt_next, w_cnt_shift;
   logic [WORD_W-1:0]   r_word, w_word_next;
   logic                r_valid, w_valid_next;
   logic                r_last, w_last_next;
   logic                r_overflow, w_overflow_next;
   logic [15:0]         r_word_cnt, w_word_cnt_next;

   logic [FRAME_SIZE-1:0] w_msg;
   logic                  w_busy, w_accept, w_free, w_xfer, w_partial;
   logic                  w_flush_start, w_flushing, w_emit;
   logic                  w_unused_frame;

   // Only the LSB of each sample carries message data.
   assign w_unused_frame = ^in_frame;

   always_comb begin
      for (int i = 0; i < FRAME_SIZE; i++) begin
         w_msg[i] = in_frame[i*BPS];
      end
   end

   assign w_busy        = (r_state == ST_FLUSH) | (r_cnt > WORD_CNT);
   assign w_accept      = in_enable & ~w_busy;
   assign w_free        = ~r_valid | in_word_ack;
   assign w_xfer        = (r_cnt >= WORD_CNT) & w_free;
   assign w_partial     = (r_state == ST_FLUSH) & (r_cnt != '0) & (r_cnt < WORD_CNT) & w_free;
   assign w_flush_start = (r_state == ST_RUN) & in_flush & ((r_cnt != '0) | w_accept);
   assign w_flushing    = (r_state == ST_FLUSH) | w_flush_start;
   assign w_emit        = w_xfer | w_partial;

   // Bits of r_acc at and above r_cnt are always zero, so new bits are OR-ed in
   // and a partial word is already zero-padded.
   assign w_cnt_shift = w_xfer ? (r_cnt - WORD_CNT) : r_cnt;
   assign w_acc_shift = w_xfer ? (r_acc >> WORD_W) : r_acc;
   assign w_msg_ext   = ACC_W'(w_msg) << w_cnt_shift;

   always_comb begin
      // NOTE: every variable gets a default first so no latch is inferred.
      w_acc_next      = w_acc_shift;
      w_cnt_next      = w_cnt_shift;
      w_word_next     = r_word;
      w_valid_next    = r_valid;
      w_last_next     = r_last;
      w_overflow_next = r_overflow | (in_enable & w_busy);
      w_word_cnt_next = r_word_cnt + {15'd0, r_valid & in_word_ack};
      w_state_next    = ST_RUN;

      if (w_partial) begin
         w_acc_next = '0;
         w_cnt_next = '0;
      end else if (w_accept) begin
         w_acc_next = w_acc_shift | w_msg_ext;
         w_cnt_next = w_cnt_shift + FS_CNT;
      end

      if (w_emit) begin
         w_word_next  = r_acc[WORD_W-1:0];
         w_valid_next = 1'b1;
         w_last_next  = w_flushing & (w_cnt_next == '0);
      end else if (in_word_ack) begin
         w_valid_next = 1'b0;
      end

      if (w_flushing && (w_cnt_next != '0)) begin
         w_state_next = ST_FLUSH;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         r_state    <= ST_RUN;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_word     <= '0;
         r_valid    <= 1'b0;
         r_last     <= 1'b0;
         r_overflow <= 1'b0;
         r_word_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_acc      <= w_acc_next;
         r_cnt      <= w_cnt_next;
         r_word     <= w_word_next;
         r_valid    <= w_valid_next;
         r_last     <= w_last_next;
         r_overflow <= w_overflow_next;
         r_word_cnt <= w_word_cnt_next;
      end
   end

   assign out_busy     = w_busy;
   assign out_word     = r_word;
   assign out_valid    = r_valid;
   assign out_last     = r_last;
   assign out_overflow = r_overflow;
   assign out_word_cnt = r_word_cnt;

endmodule

// File: tb/tb_lsb_message_extractor.sv
// Bench for lsb_message_extractor (3 samples/frame, 8-bit words): a bit-queue
// model checked every cycle plus directed scenarios with literal expectations.
module tb_lsb_message_extractor;

   localparam int FS  = 3;
   localparam int BPS = 8;
   localparam int W   = 8;

   logic              in_clk = 1'b0;
   logic              in_rst;
   logic              in_enable;
   logic [FS*BPS-1:0] in_frame;
   logic              in_flush;
   logic              in_word_ack;
   logic              out_busy;
   logic [W-1:0]      out_word;
   logic              out_valid;
   logic              out_last;
   logic              out_overflow;
   logic [15:0]       out_word_cnt;

   lsb_message_extractor #(.FRAME_SIZE(FS), .BPS(BPS), .WORD_W(W)) u_dut (
      .in_clk       (in_clk),
      .in_rst       (in_rst),
      .in_enable    (in_enable),
      .in_frame     (in_frame),
      .in_flush     (in_flush),
      .in_word_ack  (in_word_ack),
      .out_busy     (out_busy),
      .out_word     (out_word),
      .out_valid    (out_valid),
      .out_last     (out_last),
      .out_overflow (out_overflow),
      .out_word_cnt (out_word_cnt)
   );

   always #5 in_clk = ~in_clk;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: pending message bits as a queue, plus the output register.
   bit          q[$];
   logic [W-1:0] m_word;
   logic        m_valid, m_last, m_ovf, m_flush;
   logic [15:0] m_cnt;

   task automatic model_step();
      int      n;
      bit      busy, free, take, start, flushing, emitted;
      logic [W-1:0] word;
      if (in_rst) begin
         q.delete();
         m_word = '0; m_valid = 0; m_last = 0; m_ovf = 0; m_flush = 0; m_cnt = '0;
         return;
      end
      n        = q.size();
      busy     = m_flush || (n > W);
      free     = !m_valid || in_word_ack;
      take     = in_enable && !busy;
      start    = !m_flush && in_flush && (n > 0 || take);
      flushing = m_flush || start;
      emitted  = 0;
      word     = '0;
      if (m_valid && in_word_ack) m_cnt = m_cnt + 16'd1;
      if (in_enable && busy) m_ovf = 1;
      if (n >= W && free) begin
         for (int i = 0; i < W; i++) word[i] = q.pop_front();
         emitted = 1;
      end else if (m_flush && n > 0 && free) begin
         for (int i = 0; i < n; i++) word[i] = q.pop_front();
         emitted = 1;
      end
      if (take) for (int i = 0; i < FS; i++) q.push_back(in_frame[i*BPS]);
      if (emitted) begin
         m_valid = 1;
         m_word  = word;
         m_last  = flushing && (q.size() == 0);
      end else if (in_word_ack) begin
         m_valid = 0;
      end
      m_flush = flushing && (q.size() != 0);
   endtask

   always @(posedge in_clk) model_step();

   always @(negedge in_clk) begin
      if (cmp_en) begin
         check("busy", {31'd0, out_busy}, {31'd0, m_flush || (q.size() > W)});
         check("valid", {31'd0, out_valid}, {31'd0, m_valid});
         check("overflow", {31'd0, out_overflow}, {31'd0, m_ovf});
         check("word_cnt", {16'd0, out_word_cnt}, {16'd0, m_cnt});
         if (m_valid) begin
            check("word", {24'd0, out_word}, {24'd0, m_word});
            check("last", {31'd0, out_last}, {31'd0, m_last});
         end
      end
   end

   task automatic tick();
      @(posedge in_clk);
      #1;
   endtask

   function automatic logic [FS*BPS-1:0] make_frame(input logic [FS-1:0] msg);
      logic [FS*BPS-1:0] f;
      logic [BPS-1:0]    s;
      f = '0;
      for (int i = 0; i < FS; i++) begin
         s    = BPS'($urandom_range(0, 255));
         s[0] = msg[i];
         f[i*BPS +: BPS] = s;
      end
      return f;
   endfunction

   task automatic send(input logic [FS-1:0] msg, input bit wait_ready);
      int k = 0;
      if (wait_ready) begin
         while (out_busy && k < 50) begin tick(); k++; end
         if (out_busy) check("ready_timeout", {31'd0, out_busy}, 32'd0);
      end
      in_enable = 1'b1;
      in_frame  = make_frame(msg);
      tick();
      in_enable = 1'b0;
   endtask

   task automatic expect_word(input string nm, input logic [W-1:0] w, input logic l);
      int k = 0;
      while (!out_valid && k < 20) begin tick(); k++; end
      check({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({nm, "_word"}, {24'd0, out_word}, {24'd0, w});
      check({nm, "_last"}, {31'd0, out_last}, {31'd0, l});
   endtask

   task automatic flush_pulse();
      in_flush = 1'b1;
      tick();
      in_flush = 1'b0;
   endtask

   task automatic check_reset_outputs(input string nm);
      check({nm, "_valid"}, {31'd0, out_valid}, 32'd0);
      check({nm, "_word"}, {24'd0, out_word}, 32'd0);
      check({nm, "_last"}, {31'd0, out_last}, 32'd0);
      check({nm, "_ovf"}, {31'd0, out_overflow}, 32'd0);
      check({nm, "_cnt"}, {16'd0, out_word_cnt}, 32'd0);
      check({nm, "_busy"}, {31'd0, out_busy}, 32'd0);
   endtask

   logic [23:0] stream;

   initial begin
      in_rst = 1'b1; in_enable = 1'b0; in_frame = '0; in_flush = 1'b0; in_word_ack = 1'b1;
      tick();
      tick();
      in_rst = 1'b0;
      cmp_en = 1'b1;
      check_reset_outputs("reset");

      // Nine ones: a full word, then a one-bit zero-padded tail on flush.
      send(3'b111, 1); send(3'b111, 1); send(3'b111, 1);
      expect_word("ones", 8'hFF, 1'b0);
      flush_pulse();
      expect_word("ones_tail", 8'h01, 1'b1);
      tick();
      check("ones_handshakes", {16'd0, out_word_cnt}, 32'd2);

      // Bits 1,0,1,1,0,0,1,0 then 0: 0x4D, tail flush gives 0x00 as last.
      send(3'b101, 1); send(3'b001, 1); send(3'b001, 1);
      expect_word("seq4d", 8'h4D, 1'b0);
      flush_pulse();
      expect_word("seq4d_tail", 8'h00, 1'b1);
      tick();
      check("seq4d_handshakes", {16'd0, out_word_cnt}, 32'd4);

      // Flush with nothing buffered does nothing.
      flush_pulse();
      tick(); tick(); tick();
      check("empty_flush_valid", {31'd0, out_valid}, 32'd0);
      check("empty_flush_busy", {31'd0, out_busy}, 32'd0);

      // Backpressure, overflow, fill to ACC_W.
      in_word_ack = 1'b0;
      send(3'b111, 1); send(3'b000, 1); send(3'b101, 1);
      expect_word("bp_a", 8'h47, 1'b0);
      send(3'b110, 1); send(3'b011, 1); send(3'b100, 1);
      check("bp_busy_at_10", {31'd0, out_busy}, 32'd1);
      check("bp_no_ovf_yet", {31'd0, out_overflow}, 32'd0);
      send(3'b111, 0);
      check("bp_ovf", {31'd0, out_overflow}, 32'd1);
      check("bp_a_held", {24'd0, out_word}, 32'h47);
      check("bp_a_valid", {31'd0, out_valid}, 32'd1);
      in_word_ack = 1'b1;
      tick();
      in_word_ack = 1'b0;
      check("bp_b_valid", {31'd0, out_valid}, 32'd1);
      check("bp_b_word", {24'd0, out_word}, 32'h3D);
      send(3'b011, 1); send(3'b010, 1);
      check("bp_cnt_eq_w_not_busy", {31'd0, out_busy}, 32'd0);
      send(3'b101, 1);
      check("bp_full_busy", {31'd0, out_busy}, 32'd1);
      in_word_ack = 1'b1;
      tick();
      in_word_ack = 1'b0;
      check("bp_c_word", {24'd0, out_word}, 32'h4E);
      check("bp_c_last", {31'd0, out_last}, 32'd0);
      flush_pulse();
      check("flush_busy", {31'd0, out_busy}, 32'd1);
      check("flush_c_held", {24'd0, out_word}, 32'h4E);

      // Reset in FLUSH with a stalled word discards everything.
      in_rst = 1'b1;
      tick();
      in_rst = 1'b0;
      check_reset_outputs("midflush_reset");

      // Eight frames carrying 24'h3CA54D; flush lands when exactly one word is left.
      in_word_ack = 1'b1;
      stream = 24'h3CA54D;
      for (int k = 0; k < 3; k++) send(stream[3*k +: 3], 1);
      expect_word("post_w1", 8'h4D, 1'b0);
      for (int k = 3; k < 6; k++) send(stream[3*k +: 3], 1);
      expect_word("post_w2", 8'hA5, 1'b0);
      for (int k = 6; k < 8; k++) send(stream[3*k +: 3], 1);
      flush_pulse();
      check("post_w3_valid", {31'd0, out_valid}, 32'd1);
      check("post_w3_word", {24'd0, out_word}, 32'h3C);
      check("post_w3_last", {31'd0, out_last}, 32'd1);
      tick();
      check("post_handshakes", {16'd0, out_word_cnt}, 32'd3);
      check("post_idle_valid", {31'd0, out_valid}, 32'd0);
      check("post_idle_busy", {31'd0, out_busy}, 32'd0);

      tick(); tick();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
